// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// ALU function codes and status bit positions mirror the ALU definition.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] CIN_ZERO  = 2'b00;
  localparam logic [1:0] CIN_ONE   = 2'b01;
  localparam logic [1:0] CIN_SAVED = 2'b10;

  localparam int STAT_CARRY = 0;
  localparam int STAT_ZERO  = 1;
  localparam int STAT_NEG   = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_PAR   = 4;
  localparam int STAT_ERR   = 5;

  localparam logic [4:0] ALU_F_ADD  = 5'h00;
  localparam logic [4:0] ALU_F_SUB  = 5'h01;
  localparam logic [4:0] ALU_F_AND  = 5'h02;
  localparam logic [4:0] ALU_F_OR   = 5'h03;
  localparam logic [4:0] ALU_F_XOR  = 5'h04;
  localparam logic [4:0] ALU_F_NOT  = 5'h05;
  localparam logic [4:0] ALU_F_SHL  = 5'h06;
  localparam logic [4:0] ALU_F_SHR  = 5'h07;
  localparam logic [4:0] ALU_F_PASS = 5'h08;

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, logic and 1-bit shifts with a 6-bit status word.
// SUB is A + ~B + Cin, so carry out means "no borrow".
module ALU
  import alu_arb_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic [4:0]       F,
  input  logic             Cin,
  output logic [Width-1:0] Out,
  output logic [5:0]       Status
);

  logic [Width:0] wide;
  logic           carry;
  logic           ovf;
  logic           err;

  always_comb begin
    wide   = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    Out    = '0;
    Status = '0;
    case (F)
      ALU_F_ADD: begin
        wide  = {1'b0, A} + {1'b0, B} + {{Width{1'b0}}, Cin};
        Out   = wide[Width-1:0];
        carry = wide[Width];
        ovf   = (A[Width-1] == B[Width-1]) && (Out[Width-1] != A[Width-1]);
      end
      ALU_F_SUB: begin
        wide  = {1'b0, A} + {1'b0, ~B} + {{Width{1'b0}}, Cin};
        Out   = wide[Width-1:0];
        carry = wide[Width];
        ovf   = (A[Width-1] != B[Width-1]) && (Out[Width-1] != A[Width-1]);
      end
      ALU_F_AND:  Out = A & B;
      ALU_F_OR:   Out = A | B;
      ALU_F_XOR:  Out = A ^ B;
      ALU_F_NOT:  Out = ~A;
      ALU_F_SHL: begin
        Out   = {A[Width-2:0], Cin};
        carry = A[Width-1];
      end
      ALU_F_SHR: begin
        Out   = {Cin, A[Width-1:1]};
        carry = A[0];
      end
      ALU_F_PASS: Out = B;
      default:    err = 1'b1;
    endcase
    Status[STAT_CARRY] = carry;
    Status[STAT_ZERO]  = (Out == '0);
    Status[STAT_NEG]   = Out[Width-1];
    Status[STAT_OVF]   = ovf;
    Status[STAT_PAR]   = ^Out;
    Status[STAT_ERR]   = err;
  end

endmodule

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester that did not win last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt
);

  always_comb begin
    gnt_valid = |req;
    gnt       = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters, round-robin, one op in flight,
// with a per-requester saved carry so multi-word arithmetic can be chained.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [9:0]         req_f,
  input  logic [3:0]         req_cin_sel,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_out,
  output logic [5:0]         rsp_status
);

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             gnt;
  logic             gnt_valid;
  logic             gnt_q;
  logic             accept;
  logic [1:0]       saved_carry;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [4:0]       sel_f;
  logic [1:0]       sel_cs;
  logic             cin_res;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       op_f;
  logic             op_cin;
  logic [WIDTH-1:0] alu_out;
  logic [5:0]       alu_status;

  rr_arbiter2 u_arb (
    .req       (req_valid),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  ALU #(.Width(WIDTH)) u_alu (
    .A      (op_a),
    .B      (op_b),
    .F      (op_f),
    .Cin    (op_cin),
    .Out    (alu_out),
    .Status (alu_status)
  );

  // Payload mux for the granted requester; Cin resolves against saved_carry as it is now.
  always_comb begin
    sel_a   = gnt ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    sel_b   = gnt ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    sel_f   = gnt ? req_f[9:5] : req_f[4:0];
    sel_cs  = gnt ? req_cin_sel[3:2] : req_cin_sel[1:0];
    cin_res = 1'b0;
    case (sel_cs)
      CIN_ZERO:  cin_res = 1'b0;
      CIN_ONE:   cin_res = 1'b1;
      CIN_SAVED: cin_res = saved_carry[gnt];
      default:   cin_res = 1'b0;
    endcase
  end

  // rst_n gates ready so nothing looks accepted while the block is held in reset.
  assign accept    = rst_n && (state == IDLE) && gnt_valid;
  assign req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[gnt_q]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a        <= '0;
      op_b        <= '0;
      op_f        <= '0;
      op_cin      <= 1'b0;
      gnt_q       <= 1'b0;
      last        <= 1'b1;
      saved_carry <= 2'b00;
      rsp_valid   <= 2'b00;
      rsp_out     <= '0;
      rsp_status  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_f   <= sel_f;
            op_cin <= cin_res;
            gnt_q  <= gnt;
            last   <= gnt;
          end
        end
        EXEC: begin
          rsp_out            <= alu_out;
          rsp_status         <= alu_status;
          saved_carry[gnt_q] <= alu_status[STAT_CARRY];
          rsp_valid          <= gnt_q ? 2'b10 : 2'b01;
        end
        RESP: begin
          if (rsp_ready[gnt_q]) rsp_valid <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random ops,
// checked against an arithmetic reference of the ALU and a simple arbitration model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [9:0]  req_f;
  logic [3:0]  req_cin_sel;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_out;
  logic [5:0]  rsp_status;

  int          tests_run;
  int          tests_failed;
  int          model_last;
  logic [1:0]  model_carry;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_f       (req_f),
    .req_cin_sel (req_cin_sel),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_out     (rsp_out),
    .rsp_status  (rsp_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {status[5:0], out[15:0]}, status = {err, par, ovf, neg, zero, carry}.
  function automatic logic [21:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] f, input logic cin);
    int unsigned full;
    logic [15:0] r;
    logic        c, v, e;
    full = 0; r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (f)
      5'h00: begin
        full = 32'(a) + 32'(b) + 32'(cin);
        r = full[15:0]; c = full[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'h01: begin
        full = 32'(a) + (32'hFFFF - 32'(b)) + 32'(cin);
        r = full[15:0]; c = full[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      5'h02: r = a & b;
      5'h03: r = a | b;
      5'h04: r = a ^ b;
      5'h05: r = ~a;
      5'h06: begin
        full = 32'(a) * 2 + 32'(cin);
        r = full[15:0]; c = full[16];
      end
      5'h07: begin
        full = 32'(a) / 2 + 32'(cin) * 32768;
        r = full[15:0]; c = a[0];
      end
      5'h08: r = b;
      default: e = 1'b1;
    endcase
    return {e, ^r, v, r[15], (r == 16'h0000), c, r};
  endfunction

  function automatic logic resolve_cin(input int i, input logic [1:0] sel);
    if (sel == 2'b01) return 1'b1;
    if (sel == 2'b10) return model_carry[i];
    return 1'b0;
  endfunction

  task automatic drive_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] f, input logic [1:0] sel);
    req_a[i*16 +: 16]     = a;
    req_b[i*16 +: 16]     = b;
    req_f[i*5 +: 5]       = f;
    req_cin_sel[i*2 +: 2] = sel;
  endtask

  task automatic wait_ready(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called on the negedge of the EXEC cycle; latency is counted in cycles from the accept cycle.
  task automatic collect(input int i, output int lat, output logic [15:0] out,
                         output logic [5:0] st);
    lat = 1;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid[i]) break;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid[i]) lat = -1;
    out = rsp_out;
    st  = rsp_status;
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
  endtask

  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] f, input logic [1:0] sel, output bit ok,
                       output int lat, output logic [15:0] out, output logic [5:0] st,
                       output logic [21:0] expv);
    drive_req(i, a, b, f, sel);
    req_valid[i] = 1'b1;
    wait_ready(i, ok);
    expv = alu_ref(a, b, f, resolve_cin(i, sel));
    @(negedge clk);
    req_valid[i] = 1'b0;
    collect(i, lat, out, st);
    if (ok && lat > 0) begin
      model_carry[i] = expv[16];
      model_last     = i;
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    drive_req(0, 16'($urandom), 16'($urandom), 5'h00, 2'b00);
    drive_req(1, 16'($urandom), 16'($urandom), 5'h04, 2'b01);
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (req_ready !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready);
    end
    tests_run++;
    if (rsp_valid !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", rsp_valid);
    end
    tests_run++;
    if (rsp_out !== 16'h0000) begin
      tests_failed++; $display("[TB] FAIL reset_rsp_out: got %h expected 0000", rsp_out);
    end
    tests_run++;
    if (rsp_status !== 6'h00) begin
      tests_failed++; $display("[TB] FAIL reset_rsp_status: got %h expected 00", rsp_status);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_last  = 1;
    model_carry = 2'b00;
  endtask

  task automatic test_contention();
    logic [15:0] a[2];
    logic [15:0] b[2];
    logic [4:0]  f[2];
    logic [1:0]  s[2];
    logic [1:0]  onehot;
    logic [21:0] expv;
    bit          seen;
    int          g;
    for (int r = 0; r < 2; r++) begin
      a[r] = 16'($urandom); b[r] = 16'($urandom);
      f[r] = 5'($urandom_range(0, 9)); s[r] = 2'($urandom_range(0, 3));
      drive_req(r, a[r], b[r], f[r], s[r]);
    end
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = (model_last == 1) ? 0 : 1;
      onehot = (g == 0) ? 2'b01 : 2'b10;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (req_ready != 2'b00) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      tests_run++;
      if (!seen || req_ready !== onehot) begin
        tests_failed++;
        $display("[TB] FAIL contention_grant: op %0d got req_ready %b expected %b", k, req_ready, onehot);
      end
      expv = alu_ref(a[g], b[g], f[g], resolve_cin(g, s[g]));
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL contention_exec: got rsp_valid %b req_ready %b expected 00 00", rsp_valid, req_ready);
      end
      a[g] = 16'($urandom); b[g] = 16'($urandom);
      f[g] = 5'($urandom_range(0, 9)); s[g] = 2'($urandom_range(0, 3));
      drive_req(g, a[g], b[g], f[g], s[g]);
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== onehot) begin
        tests_failed++; $display("[TB] FAIL contention_rsp_valid: got %b expected %b", rsp_valid, onehot);
      end
      tests_run++;
      if ({rsp_status, rsp_out} !== expv) begin
        tests_failed++;
        $display("[TB] FAIL contention_result: got %h/%h expected %h/%h", rsp_status, rsp_out, expv[21:16], expv[15:0]);
      end
      model_carry[g] = expv[16];
      model_last     = g;
      rsp_ready[g] = 1'b1;
      @(negedge clk);
      rsp_ready[g] = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_single_op();
    bit ok; int lat; logic [15:0] out; logic [5:0] st; logic [21:0] expv;
    do_op(0, 16'h1234, 16'h0F0F, 5'h00, 2'b01, ok, lat, out, st, expv);
    tests_run++;
    if (!ok || lat != 2) begin
      tests_failed++; $display("[TB] FAIL single_latency: got ok=%0d lat=%0d expected ok=1 lat=2", ok, lat);
    end
    tests_run++;
    if (out !== 16'h2144) begin
      tests_failed++; $display("[TB] FAIL single_out: got %h expected 2144", out);
    end
    tests_run++;
    if (st !== expv[21:16]) begin
      tests_failed++; $display("[TB] FAIL single_status: got %h expected %h", st, expv[21:16]);
    end
  endtask

  task automatic test_carry_chain();
    bit ok; int lat; logic [15:0] out; logic [5:0] st; logic [21:0] expv;
    do_op(1, 16'hFFFF, 16'h0001, 5'h00, 2'b00, ok, lat, out, st, expv);
    tests_run++;
    if (!ok || out !== 16'h0000 || st[0] !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL chain_low_word: got out %h carry %b expected 0000 1", out, st[0]);
    end
    do_op(0, 16'($urandom), 16'($urandom), 5'h00, 2'b00, ok, lat, out, st, expv);
    tests_run++;
    if (!ok || {st, out} !== expv) begin
      tests_failed++; $display("[TB] FAIL chain_other_req: got %h/%h expected %h/%h", st, out, expv[21:16], expv[15:0]);
    end
    do_op(1, 16'h0000, 16'h0000, 5'h00, 2'b10, ok, lat, out, st, expv);
    tests_run++;
    if (!ok || out !== 16'h0001) begin
      tests_failed++; $display("[TB] FAIL chain_high_word: got %h expected 0001", out);
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; logic [15:0] out; logic [5:0] st;
    logic [21:0] exp0, exp1, held;
    logic [15:0] a0, b0, a1, b1;
    a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    drive_req(0, a0, b0, 5'h01, 2'b01);
    drive_req(1, a1, b1, 5'h00, 2'b10);
    req_valid[0] = 1'b1;
    wait_ready(0, ok);
    exp0 = alu_ref(a0, b0, 5'h01, 1'b1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    #1;
    tests_run++;
    if (!ok || req_ready !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL bp_exec_ready: got %b expected 00", req_ready);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 2'b01 || {rsp_status, rsp_out} !== exp0) begin
      tests_failed++;
      $display("[TB] FAIL bp_first_rsp: got %b %h/%h expected 01 %h/%h", rsp_valid, rsp_status, rsp_out, exp0[21:16], exp0[15:0]);
    end
    model_carry[0] = exp0[16];
    model_last     = 0;
    held = {rsp_status, rsp_out};
    rsp_ready[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 2'b01 || {rsp_status, rsp_out} !== held || req_ready !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold: cycle %0d got %b %h ready %b expected 01 %h ready 00", k, rsp_valid, {rsp_status, rsp_out}, req_ready, held);
      end
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    tests_run++;
    if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL bp_next_accept: got ready %b valid %b expected 10 00", req_ready, rsp_valid);
    end
    exp1 = alu_ref(a1, b1, 5'h00, model_carry[1]);
    @(negedge clk);
    req_valid[1] = 1'b0;
    collect(1, lat, out, st);
    tests_run++;
    if (lat != 2 || {st, out} !== exp1) begin
      tests_failed++; $display("[TB] FAIL bp_second_rsp: got lat %0d %h/%h expected 2 %h/%h", lat, st, out, exp1[21:16], exp1[15:0]);
    end
    model_carry[1] = exp1[16];
    model_last     = 1;
  endtask

  task automatic test_reserved_select();
    bit ok; int lat; logic [15:0] out; logic [5:0] st; logic [21:0] expv;
    do_op(0, 16'hFFFF, 16'h0001, 5'h00, 2'b00, ok, lat, out, st, expv);
    tests_run++;
    if (!ok || st[0] !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reserved_setup_carry: got %b expected 1", st[0]);
    end
    do_op(0, 16'h1234, 16'h1111, 5'h00, 2'b11, ok, lat, out, st, expv);
    tests_run++;
    if (!ok || out !== 16'h2345 || st !== expv[21:16]) begin
      tests_failed++; $display("[TB] FAIL reserved_select: got %h/%h expected %h/2345", st, out, expv[21:16]);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok; int lat; logic [15:0] out; logic [5:0] st; logic [21:0] expv;
    do_op(1, 16'hFFFF, 16'h0002, 5'h00, 2'b00, ok, lat, out, st, expv);
    tests_run++;
    if (!ok || out !== 16'h0001 || st[0] !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL midreset_setup: got %h carry %b expected 0001 1", out, st[0]);
    end
    drive_req(0, 16'h0001, 16'h0001, 5'h00, 2'b10);
    req_valid[0] = 1'b1;
    wait_ready(0, ok);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    tests_run++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_out !== 16'h0000 || rsp_status !== 6'h00) begin
      tests_failed++;
      $display("[TB] FAIL midreset_async: got ready %b valid %b out %h st %h expected all zero", req_ready, rsp_valid, rsp_out, rsp_status);
    end
    req_valid = 2'b00;
    #1;
    rst_n = 1'b1;
    model_carry = 2'b00;
    model_last  = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 2'b00) begin
        tests_failed++; $display("[TB] FAIL midreset_no_rsp: cycle %0d got %b expected 00", k, rsp_valid);
      end
    end
    do_op(1, 16'h0000, 16'h0000, 5'h00, 2'b10, ok, lat, out, st, expv);
    tests_run++;
    if (!ok || out !== 16'h0000) begin
      tests_failed++; $display("[TB] FAIL midreset_carry1_cleared: got %h expected 0000", out);
    end
    do_op(0, 16'h0000, 16'h0000, 5'h00, 2'b10, ok, lat, out, st, expv);
    tests_run++;
    if (!ok || out !== 16'h0000) begin
      tests_failed++; $display("[TB] FAIL midreset_carry0_cleared: got %h expected 0000", out);
    end
  endtask

  task automatic test_random();
    bit ok; int lat; int i; logic [15:0] out; logic [5:0] st; logic [21:0] expv;
    for (int k = 0; k < 30; k++) begin
      i = $urandom_range(0, 1);
      do_op(i, 16'($urandom), 16'($urandom), 5'($urandom_range(0, 9)), 2'($urandom_range(0, 3)),
            ok, lat, out, st, expv);
      tests_run++;
      if (!ok || lat != 2 || {st, out} !== expv) begin
        tests_failed++;
        $display("[TB] FAIL random_op: op %0d req %0d got ok %0d lat %0d %h/%h expected lat 2 %h/%h", k, i, ok, lat, st, out, expv[21:16], expv[15:0]);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_last   = 1;
    model_carry  = 2'b00;
    rst_n        = 1'b0;
    req_valid    = 2'b00;
    rsp_ready    = 2'b00;
    req_a        = '0;
    req_b        = '0;
    req_f        = '0;
    req_cin_sel  = '0;
    test_reset();
    test_contention();
    test_single_op();
    test_carry_chain();
    test_backpressure();
    test_reserved_select();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `ALU` datapath instance (WIDTH-bit A/B, 5-bit F, Cin, Out, 6-bit Status) between two independent requesters. Each requester issues operations with a valid/ready handshake and receives the result and status on its own response channel. Grants are round-robin. The block keeps a per-requester saved carry flag, so multi-word arithmetic can be chained without the requester feeding Cin back.

## Interface
- `WIDTH`, 16, operand/result width passed to the ALU instance
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  2  per-requester operation valid (bit i = requester i)
- `req_ready`  out  2  per-requester accept; at most one bit high
- `req_a`  in  2*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
- `req_b`  in  2*WIDTH  operand B, same packing
- `req_f`  in  2*5  ALU function code, requester i in bits [i*5 +: 5]
- `req_cin_sel`  in  2*2  Cin source: 00 → 0, 01 → 1, 10 → saved carry of that requester, 11 → 0 (reserved)
- `rsp_valid`  out  2  result valid for requester i
- `rsp_ready`  in  2  requester i accepts result
- `rsp_out`  out  WIDTH  result, shared bus, meaningful for the asserted rsp_valid bit
- `rsp_status`  out  6  ALU status, shared bus

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbiter picks the grant `g` from `req_valid` and the round-robin pointer `last`.
  - When both requesters are valid, the requester ≠ `last` wins.
  - When one requester is valid, it wins.
  - `req_ready[g]` is high combinationally in IDLE only when `req_valid[g]` is high.
  - On handshake: latch A, B, F and the resolved Cin into operand registers, record `g` and set `last <= g`, then go to EXEC.
- **EXEC**
  - The ALU sees the registered operands.
  - Capture Out into `rsp_out` and Status into `rsp_status`.
  - Set `saved_carry[g] <= Status[STAT_CARRY]` and `rsp_valid[g] <= 1`, then go to RESP.
- **RESP**
  - Hold `rsp_valid[g]`, `rsp_out` and `rsp_status` stable.
  - On `rsp_ready[g]`: clear `rsp_valid`, go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- `req_ready` is 0 in EXEC and RESP; no new request is accepted while an op is outstanding.
- Cin resolution uses `saved_carry` as it stands at the accept cycle.
- `saved_carry[i]` changes only when requester i's own op completes EXEC.
- Reset values:
  - `state` = IDLE
  - `rsp_valid` = 00, `rsp_out` = 0, `rsp_status` = 0
  - `saved_carry` = 00
  - operand registers = 0
  - `last` = 1, so requester 0 wins the first contention
  - `req_ready` = 00 while `rst_n` is low
- Reset mid-operation (EXEC or RESP):
  - Immediate return to the reset values.
  - The in-flight op is dropped: no response, no carry update.
- All arithmetic and flag semantics are the ALU's own; this block adds no width extension and no truncation.

## Timing
- Request accepted in cycle T (valid & ready high at edge T):
  - EXEC during T+1.
  - `rsp_valid` high from edge T+2.
- Response accepted at edge R (with `rsp_ready` high): IDLE during R+1; next accept at edge R+1 at the earliest.
- Peak throughput is one op per 3 cycles, shared between requesters.
- Requester protocol:
  - A pending `req_valid` must stay high with stable payload until `req_ready`.
  - The block does not depend on this for correctness; it samples the payload only at the handshake edge.

## Structure
- Package `alu_arb_pkg` holds:
  - the state enum (IDLE/EXEC/RESP)
  - Cin-select constants (`CIN_ZERO`, `CIN_ONE`, `CIN_SAVED`)
  - `STAT_CARRY` (carry bit index in Status)
  - `ALU_F_ADD` (ADD function code), mirrored from the ALU definition
- Sub-module `rr_arbiter2`: combinational 2-way round-robin grant from `req_valid` and `last`.
- Top instantiates `rr_arbiter2` and one `ALU #(.Width(WIDTH))`.

## Test plan
- **Single op:** req0 with A=16'h1234, B=16'h0F0F, F=5'h00, cin_sel=01. Expect `rsp_valid[0]` exactly 2 cycles after accept, and Out/Status equal to the ALU model for those inputs with Cin=1.
- **Contention:** both requesters valid continuously from reset. Expect grant order 0,1,0,1. Each response goes to the correct `rsp_valid` bit, and `req_ready` is never 2'b11.
- **Carry chain:**
  - req1 ADD with A=16'hFFFF, B=16'h0001, cin_sel=00 → Out 16'h0000, Status[STAT_CARRY]=1.
  - Then req1 ADD with A=0, B=0, cin_sel=10 → Out 16'h0001.
  - A req0 op in between must not disturb `saved_carry[1]`.
- **Backpressure:** hold `rsp_ready[0]` low for 5 cycles with req1 pending. Expect `rsp_valid[0]`, Out and Status stable, and `req_ready`=00. req1 is accepted 1 cycle after the req0 response handshake.
- **Reset mid-op:** drop `rst_n` during EXEC. Expect all outputs 0 asynchronously, no response after release, and `saved_carry`=00. The first op after reset with cin_sel=10 uses Cin=0.
- **Reserved select:** cin_sel=11 while `saved_carry`=1 → result equals the ALU model with Cin=0.
